// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives instr_mem, fills the IF/ID register
// and counts fetched instructions, honouring redirect > flush > stall priority.
module fetch_stage #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] PC_STEP  = 16'h0002
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_instr,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    output logic        if_id_valid,
    output logic [15:0] if_id_instr,
    output logic [15:0] if_id_pc,
    output logic [15:0] if_id_pc_plus2,
    output logic [15:0] fetch_count
);

    localparam logic [15:0] BOOT_PC = RESET_PC & 16'hFFFE;

    typedef enum logic [0:0] {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t      state_r, state_s;
    logic [15:0] pc_r, pc_s;
    logic        valid_r, valid_s;
    logic [15:0] instr_r, instr_s;
    logic [15:0] ifpc_r, ifpc_s;
    logic [15:0] ifpc2_r, ifpc2_s;
    logic [15:0] count_r, count_s;
    logic [15:0] pc_inc_s;

    assign pc_inc_s = pc_r + PC_STEP;

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= BOOT;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and next-datapath decode; everything holds unless an action applies
    always_comb begin
        state_s = state_r;
        pc_s    = pc_r;
        valid_s = valid_r;
        instr_s = instr_r;
        ifpc_s  = ifpc_r;
        ifpc2_s = ifpc2_r;
        count_s = count_r;
        case (state_r)
            BOOT: begin
                // single idle cycle after reset so instr_mem sees a stable PC first
                state_s = RUN;
            end
            RUN: begin
                state_s = RUN;
                if (redirect_valid) begin
                    pc_s    = redirect_pc & 16'hFFFE;
                    valid_s = 1'b0;
                    instr_s = 16'h0000;
                end else if (flush) begin
                    valid_s = 1'b0;
                    instr_s = 16'h0000;
                    if (stall) begin
                        pc_s = pc_r;
                    end else begin
                        pc_s = pc_inc_s;
                    end
                end else if (stall) begin
                    pc_s = pc_r;
                end else begin
                    instr_s = imem_instr;
                    ifpc_s  = pc_r;
                    ifpc2_s = pc_inc_s;
                    valid_s = 1'b1;
                    pc_s    = pc_inc_s;
                    if (count_r != 16'hFFFF) begin
                        count_s = count_r + 16'h0001;
                    end else begin
                        count_s = count_r;
                    end
                end
            end
            default: begin
                state_s = BOOT;
            end
        endcase
    end

    // PC, IF/ID pipeline register and fetch counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_r    <= BOOT_PC;
            valid_r <= 1'b0;
            instr_r <= 16'h0000;
            ifpc_r  <= 16'h0000;
            ifpc2_r <= 16'h0000;
            count_r <= 16'h0000;
        end else begin
            pc_r    <= pc_s;
            valid_r <= valid_s;
            instr_r <= instr_s;
            ifpc_r  <= ifpc_s;
            ifpc2_r <= ifpc2_s;
            count_r <= count_s;
        end
    end

    assign imem_addr      = pc_r;
    assign if_id_valid    = valid_r;
    assign if_id_instr    = instr_r;
    assign if_id_pc       = ifpc_r;
    assign if_id_pc_plus2 = ifpc2_r;
    assign fetch_count    = count_r;

endmodule
